mem_burst_ctrl: RTL and testbench

- Parametrised behavioural main-memory model with a programmable wait-state count and wrapping critical-word-first read bursts.
- Byte-enabled single-word writes.
- Sits on the SoC memory port behind the cache/bus; successor to the fixed 2-wait-state memory model.
- One request in flight at a time; MReady is the accept handshake, MReadValid qualifies each read beat.

---
 rtl/mem_burst_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mem_burst_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_ctrl.sv
// Behavioural main-memory model with a programmable wait-state count,
// wrapping critical-word-first read bursts and byte-enabled single-word writes.
module mem_burst_ctrl #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 18,
    parameter int WAIT_STATE = 2,
    parameter int BURST_LEN  = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                MEnable,
    input  logic                MRead,
    input  logic                MWrite,
    input  logic [ADDR_W-1:0]   MAddress,
    input  logic [DATA_W/8-1:0] MByteEn,
    input  logic [DATA_W-1:0]   MWriteData,
    output logic [DATA_W-1:0]   MReadData,
    output logic                MReadValid,
    output logic                MReady
);

    localparam int WORD_W = ADDR_W - 2;
    localparam int DEPTH  = 2 ** WORD_W;
    localparam int BE_W   = DATA_W / 8;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [WORD_W-1:0] BLK_MASK  = WORD_W'(BURST_LEN - 1);
    localparam logic [3:0]        WAIT_LOAD = 4'((WAIT_STATE > 0) ? WAIT_STATE - 1 : 0);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    // WCOMMIT is the write-side wait; the word is committed on its last cycle
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RBURST,
        WCOMMIT
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [WORD_W-1:0] r_wordAddr;
    logic [BE_W-1:0]   r_byteEn;
    logic [DATA_W-1:0] r_writeData;
    logic [3:0]        r_waitCnt;
    logic [BEAT_W-1:0] r_beatCnt;
    logic [DATA_W-1:0] r_readData;
    logic              r_readValid;

    logic [WORD_W-1:0] w_inWord;
    logic              w_accept;
    logic              w_waitLast;
    logic              w_lastBeat;
    logic [WORD_W-1:0] w_nextBeatAddr;
    logic              w_commit;
    logic [WORD_W-1:0] w_commitAddr;
    logic [DATA_W-1:0] w_commitData;
    logic [BE_W-1:0]   w_commitBe;
    logic              w_loadBeat;
    logic [WORD_W-1:0] w_loadAddr;
    logic              w_unusedAddrLsb;

    assign w_inWord        = MAddress[ADDR_W-1:2];
    assign w_unusedAddrLsb = ^MAddress[1:0];
    assign w_accept        = MEnable && MReady && (MRead || MWrite);
    assign w_waitLast      = (r_waitCnt == 4'd0);
    assign w_lastBeat      = (r_beatCnt == LAST_BEAT);

    // Next beat stays inside the aligned block: only the low offset bits advance
    assign w_nextBeatAddr = (r_wordAddr & ~BLK_MASK)
                          | ((r_wordAddr + WORD_W'(r_beatCnt) + WORD_W'(1)) & BLK_MASK);

    assign MReady     = (r_state == IDLE);
    assign MReadValid = r_readValid;
    assign MReadData  = r_readData;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_commit     = 1'b0;
        w_commitAddr = r_wordAddr;
        w_commitData = r_writeData;
        w_commitBe   = r_byteEn;
        w_loadBeat   = 1'b0;
        w_loadAddr   = r_wordAddr;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (MRead) begin
                        if (WAIT_STATE == 0) begin
                            w_nextState = RBURST;
                            w_loadBeat  = 1'b1;
                            w_loadAddr  = w_inWord;
                        end else begin
                            w_nextState = WAIT;
                        end
                    end else begin
                        if (WAIT_STATE == 0) begin
                            w_commit     = 1'b1;
                            w_commitAddr = w_inWord;
                            w_commitData = MWriteData;
                            w_commitBe   = MByteEn;
                        end else begin
                            w_nextState = WCOMMIT;
                        end
                    end
                end
            end
            WAIT: begin
                if (w_waitLast) begin
                    w_nextState = RBURST;
                    w_loadBeat  = 1'b1;
                    w_loadAddr  = r_wordAddr;
                end
            end
            RBURST: begin
                if (w_lastBeat) begin
                    w_nextState = IDLE;
                end else begin
                    w_loadBeat = 1'b1;
                    w_loadAddr = w_nextBeatAddr;
                end
            end
            WCOMMIT: begin
                if (w_waitLast) begin
                    w_commit    = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Request capture, counters and the registered read-beat outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wordAddr  <= '0;
            r_byteEn    <= '0;
            r_writeData <= '0;
            r_waitCnt   <= 4'd0;
            r_beatCnt   <= '0;
            r_readData  <= '0;
            r_readValid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wordAddr  <= w_inWord;
                r_byteEn    <= MByteEn;
                r_writeData <= MWriteData;
                r_waitCnt   <= WAIT_LOAD;
            end else if (((r_state == WAIT) || (r_state == WCOMMIT)) && !w_waitLast) begin
                r_waitCnt <= r_waitCnt - 4'd1;
            end

            if ((r_state == RBURST) && !w_lastBeat) begin
                r_beatCnt <= r_beatCnt + 1'b1;
            end else begin
                r_beatCnt <= '0;
            end

            r_readValid <= w_loadBeat;
            if (w_loadBeat) begin
                r_readData <= r_mem[w_loadAddr];
            end
        end
    end

    // Storage is never cleared; reset only suppresses a commit on the same edge
    always_ff @(posedge clock) begin
        if (!reset && w_commit) begin
            for (int b = 0; b < BE_W; b++) begin
                if (w_commitBe[b]) begin
                    r_mem[w_commitAddr][8*b +: 8] <= w_commitData[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl: two instances (2 wait states / 4-beat
// bursts and 0 wait states / 8-beat bursts) checked against a transaction-level model.
module tb_mem_burst_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int WORDS = 64;
    localparam int WS_A  = 2;
    localparam int BL_A  = 4;
    localparam int WS_B  = 0;
    localparam int BL_B  = 8;

    typedef struct {
        bit              isWrite;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata;
        logic [3:0]      be;
        logic [DW-1:0]   expFirst;
    } vec_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          MEnable;
    logic          MRead;
    logic          MWrite;
    logic [AW-1:0] MAddress;
    logic [3:0]    MByteEn;
    logic [DW-1:0] MWriteData;

    int            curDut;
    logic          enA;
    logic          enB;
    logic [DW-1:0] rdA;
    logic [DW-1:0] rdB;
    logic          validA;
    logic          validB;
    logic          readyA;
    logic          readyB;
    logic [DW-1:0] outData;
    logic          outValid;
    logic          outReady;

    int            testsRun;
    int            testsFailed;
    logic [DW-1:0] refMem [2][WORDS];
    logic [DW-1:0] lastBeats [16];
    logic [DW-1:0] first;
    vec_t          vecs[$];

    always #5 clock = ~clock;

    assign enA      = MEnable && (curDut == 0);
    assign enB      = MEnable && (curDut == 1);
    assign outData  = (curDut == 0) ? rdA : rdB;
    assign outValid = (curDut == 0) ? validA : validB;
    assign outReady = (curDut == 0) ? readyA : readyB;

    mem_burst_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .WAIT_STATE(WS_A), .BURST_LEN(BL_A)
    ) dutA (
        .clock(clock), .reset(reset), .MEnable(enA), .MRead(MRead), .MWrite(MWrite),
        .MAddress(MAddress), .MByteEn(MByteEn), .MWriteData(MWriteData),
        .MReadData(rdA), .MReadValid(validA), .MReady(readyA)
    );

    mem_burst_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .WAIT_STATE(WS_B), .BURST_LEN(BL_B)
    ) dutB (
        .clock(clock), .reset(reset), .MEnable(enB), .MRead(MRead), .MWrite(MWrite),
        .MAddress(MAddress), .MByteEn(MByteEn), .MWriteData(MWriteData),
        .MReadData(rdB), .MReadValid(validB), .MReady(readyB)
    );

    function automatic int waitStates();
        return (curDut == 0) ? WS_A : WS_B;
    endfunction

    function automatic int burstLen();
        return (curDut == 0) ? BL_A : BL_B;
    endfunction

    // Word returned by beat k of a burst whose critical word is idx
    function automatic int beatWord(int idx, int k);
        int bl;
        int base;
        bl   = burstLen();
        base = (idx / bl) * bl;
        return base + ((idx - base) + k) % bl;
    endfunction

    function automatic logic [DW-1:0] merge(logic [DW-1:0] oldV, logic [DW-1:0] newV,
                                            logic [3:0] be);
        logic [DW-1:0] r;
        r = oldV;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = newV[8*b +: 8];
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s (dut %0d): got %h, expected %h", name, curDut, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic rd, input logic wr,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                 input logic [3:0] be);
        MEnable    = en;
        MRead      = rd;
        MWrite     = wr;
        MAddress   = addr;
        MWriteData = data;
        MByteEn    = be;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 1'($urandom), 1'($urandom), AW'($urandom), $urandom, 4'($urandom));
    endtask

    // Called just after a posedge with the DUT idle; returns just after a posedge, idle
    task automatic doRead(input logic [AW-1:0] addr, input logic alsoWrite);
        int            ws;
        int            bl;
        int            idx;
        logic [DW-1:0] exp;
        ws  = waitStates();
        bl  = burstLen();
        idx = int'(addr[AW-1:2]);
        exp = '0;
        applyStimulus(1'b1, 1'b1, alsoWrite, addr, $urandom, 4'hF);
        @(negedge clock);
        checkOutput("read accept ready", 32'(outReady), 32'd1);
        @(posedge clock); #1;
        idleInputs();
        for (int c = 1; c <= ws; c++) begin
            @(negedge clock);
            checkOutput("read wait ready", 32'(outReady), 32'd0);
            checkOutput("read wait valid", 32'(outValid), 32'd0);
        end
        for (int k = 0; k < bl; k++) begin
            @(negedge clock);
            exp = refMem[curDut][beatWord(idx, k)];
            lastBeats[k] = outData;
            checkOutput("beat valid", 32'(outValid), 32'd1);
            checkOutput("beat data", outData, exp);
            checkOutput("beat ready", 32'(outReady), 32'd0);
        end
        @(negedge clock);
        checkOutput("post-burst ready", 32'(outReady), 32'd1);
        checkOutput("post-burst valid", 32'(outValid), 32'd0);
        checkOutput("post-burst data hold", outData, exp);
        @(posedge clock); #1;
    endtask

    task automatic doWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] be);
        int idx;
        idx = int'(addr[AW-1:2]);
        applyStimulus(1'b1, 1'b0, 1'b1, addr, data, be);
        @(negedge clock);
        checkOutput("write accept ready", 32'(outReady), 32'd1);
        @(posedge clock); #1;
        idleInputs();
        refMem[curDut][idx] = merge(refMem[curDut][idx], data, be);
        for (int c = 1; c <= waitStates(); c++) begin
            @(negedge clock);
            checkOutput("write wait ready", 32'(outReady), 32'd0);
            checkOutput("write wait valid", 32'(outValid), 32'd0);
            @(posedge clock); #1;
        end
    endtask

    task automatic randomPhase(input int count);
        for (int n = 0; n < count; n++) begin
            int            kind;
            logic [AW-1:0] a;
            kind = int'($urandom_range(0, 3));
            a    = AW'($urandom);
            if (kind == 0)      doRead(a, 1'b0);
            else if (kind == 1) doRead(a, 1'b1);
            else                doWrite(a, $urandom, 4'($urandom));
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        curDut      = 0;
        reset       = 1'b1;
        idleInputs();
        repeat (2) @(posedge clock);
        for (int d = 0; d < 2; d++) begin
            curDut = d;
            @(negedge clock);
            checkOutput("reset ready", 32'(outReady), 32'd1);
            checkOutput("reset valid", 32'(outValid), 32'd0);
            checkOutput("reset data", outData, 32'd0);
        end
        @(posedge clock); #1;
        reset = 1'b0;

        // Known contents: word i holds i
        for (int d = 0; d < 2; d++) begin
            curDut = d;
            for (int i = 0; i < WORDS; i++) doWrite(AW'(i * 4), 32'(i), 4'hF);
        end

        curDut = 0;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h30, 32'hFFFF_FFFF, 4'hF);
            @(negedge clock);
            checkOutput("no-qualifier ready", 32'(outReady), 32'd1);
            checkOutput("no-qualifier valid", 32'(outValid), 32'd0);
            @(posedge clock); #1;
        end
        idleInputs();
        doRead(8'h30, 1'b0);
        checkOutput("no-qualifier memory", lastBeats[0], 32'd12);

        vecs.push_back('{1'b1, 8'h40, 32'hDEAD_BEEF, 4'hF, 32'h0});
        vecs.push_back('{1'b0, 8'h40, 32'h0,         4'h0, 32'hDEAD_BEEF});
        vecs.push_back('{1'b1, 8'h40, 32'h1122_3344, 4'hF, 32'h0});
        vecs.push_back('{1'b1, 8'h40, 32'hAABB_CCDD, 4'h5, 32'h0});
        vecs.push_back('{1'b0, 8'h40, 32'h0,         4'h0, 32'h11BB_33DD});
        vecs.push_back('{1'b1, 8'h40, 32'hFFFF_FFFF, 4'h0, 32'h0});
        vecs.push_back('{1'b0, 8'h40, 32'h0,         4'h0, 32'h11BB_33DD});
        vecs.push_back('{1'b1, 8'h7C, 32'h0BAD_F00D, 4'hC, 32'h0});
        vecs.push_back('{1'b0, 8'h74, 32'h0,         4'h0, 32'h0000_001D});
        vecs.push_back('{1'b0, 8'h7C, 32'h0,         4'h0, 32'h0BAD_001F});
        vecs.push_back('{1'b0, 8'h18, 32'h0,         4'h0, 32'h0000_0006});
        foreach (vecs[v]) begin
            if (vecs[v].isWrite) begin
                doWrite(vecs[v].addr, vecs[v].wdata, vecs[v].be);
            end else begin
                doRead(vecs[v].addr, 1'b0);
                checkOutput("vector first beat", lastBeats[0], vecs[v].expFirst);
            end
        end

        // Critical-word-first wrap: word 6 of block 4..7
        doRead(8'h18, 1'b0);
        checkOutput("wrap beat 0", lastBeats[0], 32'd6);
        checkOutput("wrap beat 1", lastBeats[1], 32'd7);
        checkOutput("wrap beat 2", lastBeats[2], 32'd4);
        checkOutput("wrap beat 3", lastBeats[3], 32'd5);

        randomPhase(30);

        // Reset while beat 2 of a burst is on the bus
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h18, 32'h0, 4'hF);
        @(posedge clock); #1;
        idleInputs();
        repeat (WS_A + 3) @(negedge clock);
        checkOutput("mid-burst beat 2 valid", 32'(outValid), 32'd1);
        checkOutput("mid-burst beat 2 data", outData, refMem[0][beatWord(6, 2)]);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("burst abort valid", 32'(outValid), 32'd0);
        checkOutput("burst abort ready", 32'(outReady), 32'd1);
        checkOutput("burst abort data", outData, 32'd0);
        @(posedge clock); #1;

        // Reset on the last wait cycle of a write discards it
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h24, 32'h55AA_55AA, 4'hF);
        @(posedge clock); #1;
        idleInputs();
        repeat (WS_A) @(negedge clock);
        checkOutput("write wait before reset", 32'(outReady), 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("write abort ready", 32'(outReady), 32'd1);
        @(posedge clock); #1;
        doRead(8'h24, 1'b0);

        // Zero wait states: read wins over write, writes go back-to-back
        curDut = 1;
        doRead(8'h20, 1'b1);
        doRead(8'h20, 1'b0);
        checkOutput("read+write leaves memory", lastBeats[0], 32'd8);
        doWrite(8'h00, 32'hA0A0_A0A0, 4'hF);
        doWrite(8'h04, 32'hB1B1_B1B1, 4'hF);
        doWrite(8'h08, 32'h1234_5678, 4'h3);
        doRead(8'h00, 1'b0);
        checkOutput("b2b write word 0", lastBeats[0], 32'hA0A0_A0A0);
        checkOutput("b2b write word 1", lastBeats[1], 32'hB1B1_B1B1);
        checkOutput("b2b write word 2", lastBeats[2], 32'h0000_5678);
        doRead(8'h0C, 1'b0);
        checkOutput("wrap8 beat 5", lastBeats[5], 32'hA0A0_A0A0);
        checkOutput("wrap8 beat 7", lastBeats[7], 32'h0000_5678);

        randomPhase(30);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
